// File: rtl/inst_fetch_queue_if.sv
// Signal bundle for the fetch queue: instruction-memory read port, redirect
// input and the decoder-facing queue head. "master" is the fetch queue side.
interface inst_fetch_queue_if #(
    parameter int QUEUE_AW = 4
);
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ack;
    logic [31:0]         mem_data;
    logic                flush;
    logic [31:0]         flush_pc;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_inst;
    logic [31:0]         out_pc;
    logic [QUEUE_AW:0]   out_count;

    modport master (
        output mem_req, mem_addr, out_valid, out_inst, out_pc, out_count,
        input  mem_ack, mem_data, flush, flush_pc, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, out_count,
        output mem_ack, mem_data, flush, flush_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: one-outstanding sequential fetcher with JAL
// pre-decode, feeding a circular {pc, inst} queue popped by the decoder.
module inst_fetch_queue #(
    parameter int          QUEUE_AW = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                clk,
    input logic                rst_n,
    inst_fetch_queue_if.master bus
);
    localparam int                DEPTH      = 1 << QUEUE_AW;
    localparam logic [QUEUE_AW:0] FULL_COUNT = (QUEUE_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t              state;
    logic [31:0]         pc;
    logic [31:0]         mem_addr_q;
    logic [QUEUE_AW-1:0] head;
    logic [QUEUE_AW-1:0] tail;
    logic [QUEUE_AW:0]   count;
    logic [31:0]         q_pc   [DEPTH];
    logic [31:0]         q_inst [DEPTH];

    logic        push;
    logic        pop;
    logic        is_jal;
    logic [31:0] jal_imm;
    logic [31:0] next_pc;

    always_comb begin
        push    = (state == WAIT) && bus.mem_ack && !bus.flush;
        pop     = (count != '0) && bus.out_ready && !bus.flush;
        is_jal  = (bus.mem_data[6:0] == 7'h6f);
        jal_imm = {{11{bus.mem_data[31]}}, bus.mem_data[31], bus.mem_data[19:12],
                   bus.mem_data[20], bus.mem_data[30:21], 1'b0};
        // JAL is followed here so the decoder never sees a bubble behind it.
        next_pc = is_jal ? (mem_addr_q + jal_imm) : (mem_addr_q + 32'd4);
    end

    // NOTE: every register in this block uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            mem_addr_q <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            if (bus.flush) begin
                pc    <= bus.flush_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                    pc   <= next_pc;
                end
                if (pop) head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            case (state)
                IDLE: begin
                    // A request needs a guaranteed slot, so the ack can never stall.
                    if (!bus.flush && (count < FULL_COUNT)) begin
                        mem_addr_q <= pc;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ack)    state <= IDLE;
                    else if (bus.flush) state <= DROP;
                end
                DROP: begin
                    if (bus.mem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the queue storage has no reset; an entry is only read once count marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= mem_addr_q;
            q_inst[tail] <= bus.mem_data;
        end
    end

    assign bus.mem_req   = (state == WAIT) || (state == DROP);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_inst  = q_inst[head];
    assign bus.out_pc    = q_pc[head];
    assign bus.out_count = count;
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Generates sequential instruction-word fetch addresses and performs one-outstanding memory read handshakes.
- Pre-decodes JAL so fetch follows it without a bubble through execute.
- Buffers {pc, inst} pairs in a circular FIFO; the decoder/issue stage pops the FIFO head.
- A redirect (branch/JALR resolution, mispredict) flushes the queue and any in-flight fetch.

Parameters:
- QUEUE_AW, 4, log2 of queue depth (DEPTH = 2^QUEUE_AW = 16 entries).
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  read request outstanding.
- mem_addr  out  32  byte address of requested word; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse: mem_data valid, request complete; ignored when mem_req=0.
- mem_data  in  32  instruction word returned with mem_ack.
- flush  in  1  redirect pulse; highest priority.
- flush_pc  in  32  new fetch pc, sampled when flush=1.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_inst  out  32  head instruction word.
- out_pc  out  32  head instruction pc.
- out_count  out  QUEUE_AW+1  current occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; head=tail=0; count=0.
  - mem_req=0; mem_addr=0; out_valid=0; out_count=0.
  - Queue array contents are don't-care.
- State machine. Registered states IDLE, WAIT, DROP; mem_req = (state==WAIT || state==DROP).
  - IDLE:
    - If flush=0 and count<DEPTH: mem_addr<=pc; go to WAIT. mem_req rises the next cycle.
    - Else stay in IDLE.
  - WAIT, mem_ack=0, flush=0: stay in WAIT; mem_addr held.
  - WAIT, mem_ack=1, flush=0:
    - Push {mem_addr, mem_data} at tail; tail++.
    - Next pc: if mem_data[6:0]==7'h6f, pc <= mem_addr + sext(J-imm). J-imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign-extended from bit 20.
    - Otherwise pc <= mem_addr + 4.
    - Go to IDLE.
  - WAIT, flush=1, mem_ack=0: discard request; go to DROP.
  - WAIT, flush=1, mem_ack=1: drop data, no push; go to IDLE.
  - DROP: mem_addr held. On mem_ack: discard data; go to IDLE. A flush in DROP only updates pc.
  - Any state, flush=1: pc<=flush_pc; head=tail=count=0. No push or pop that cycle.
- Throughput: at most one fetch per 2 cycles plus memory latency. Each request needs one IDLE cycle after ack.
- Full/space: a request is issued only when count<DEPTH. Only one request is outstanding, so every push has a free slot. The block never overflows and never stalls an ack.
- Output side:
  - out_valid = (count!=0).
  - out_inst/out_pc are read combinationally from the head entry.
  - Pop when out_valid && out_ready && !flush; head++.
  - Pop while empty: no effect.
- Simultaneous push and pop in one cycle: count unchanged; head and tail both advance.
- Wrap-around:
  - head/tail are QUEUE_AW bits and wrap modulo DEPTH.
  - count is QUEUE_AW+1 bits and ranges 0..DEPTH.
- Arithmetic: all pc math is 32-bit modulo 2^32. pc[1:0] is never checked.
- Reset mid-transaction: state returns to IDLE immediately and mem_req drops. The memory side must tolerate an abandoned request.

Test Plan:
1. Reset, then mem_ack 2 cycles after each mem_req with data 32'h00000013 (addi). Required: mem_addr sequence 0,4,8,12; queue holds pcs 0,4,8,12; out_count=4 with out_ready=0.
2. Hold out_ready=0 for 40+ cycles. Required:
   - out_count saturates at 16; mem_req stays 0 once count=16.
   - Asserting out_ready for one cycle pops pc 0, count goes to 15, and a request for pc 64 is issued.
3. At pc 0x100, return 32'h0080006f (jal x0,+8). Required: next mem_addr=0x108; queue entry shows pc 0x100, inst 32'h0080006f. Repeat with 32'hff9ff06f (jal -8): next mem_addr=0xF8.
4. flush=1 with flush_pc=0x200 while in WAIT, then mem_ack arrives 3 cycles later with 32'hdeadbeef. Required:
   - out_valid=0 after the flush; the ack data is never pushed.
   - The next request address is 0x200.
5. flush asserted in the same cycle as mem_ack. Required: no push; state IDLE; next mem_addr=flush_pc.
6. Queue at count=16 with head at index 15: pop and push in the same cycles across wrap. Required: FIFO order preserved (pcs strictly +4); count unchanged on simultaneous push/pop.
